// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory responder.
//   - mem_state_e : responder FSM states
//   - SEL_MDR_*   : selMDR source encodings
//   - ADDR_*      : memory-mapped device register addresses (used when
//                   LC3_MMIO_EN is defined)
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } mem_state_e;

  localparam logic [1:0] SEL_MDR_BUS = 2'b00;  // immediate load from bus_in
  localparam logic [1:0] SEL_MDR_MEM = 2'b01;  // memory read request

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  // True when a full 16-bit address hits one of the device registers.
  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
           (addr == ADDR_DSR)  || (addr == ADDR_DDR);
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: 2^DEPTH_LOG2 x 16-bit RAM, synchronous write, asynchronous
// read. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data
module lc3_mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem_q [2**DEPTH_LOG2];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: memory-side responder for the LC-3 control strobes.
// Owns MAR/MDR and the RAM, performs multi-cycle reads/writes with a
// four-phase mem_ready handshake, and accepts the preload write path.
// Optional feature macro: LC3_MMIO_EN adds keyboard/display device registers.
//   clk, reset (async, active-low)
//   bus_in, ldMAR, ldMDR, selMDR, memWE       : datapath requests
//   MARSpcIn, MDRSpcIn, ldMARSpcIn            : preload write path
//   mar_out, mdr_out, mem_ready, busy         : registered status/data
//   kb_data, kb_valid, disp_data, disp_valid  : device ports (LC3_MMIO_EN)
module lc3_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic [1:0]  selMDR,
  input  logic        memWE,
  input  logic [15:0] MARSpcIn,
  input  logic [15:0] MDRSpcIn,
  input  logic        ldMARSpcIn,
`ifdef LC3_MMIO_EN
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
`endif
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic        mem_ready,
  output logic        busy
);
  import lc3_mem_pkg::*;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic [15:0] addr_q;   // access address captured at acceptance
  logic        is_wr_q;  // originating request type, needed in DONE
  logic        ready_q;
  logic        busy_q;

  logic        rd_req_s;
  logic        wr_req_s;
  logic        orig_req_s;
  logic        last_s;   // final wait cycle: completion on this edge
  logic        addr_mmio_s;
  logic [15:0] rd_data_s;
  logic [15:0] ram_rdata_s;
  logic        ram_we_s;
  logic [DEPTH_LOG2-1:0] ram_waddr_s;
  logic [15:0] ram_wdata_s;

  assign rd_req_s   = ldMDR && (selMDR == SEL_MDR_MEM);
  assign wr_req_s   = memWE;
  assign orig_req_s = is_wr_q ? wr_req_s : rd_req_s;
  assign last_s     = ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) &&
                      (cnt_q == 4'd0);

`ifdef LC3_MMIO_EN
  logic       kb_ready_q;
  logic [7:0] kb_data_q;
  logic [7:0] disp_data_q;
  logic       disp_valid_q;

  assign addr_mmio_s = is_mmio(addr_q);

  // Device register read mux; non-device addresses read the RAM.
  always_comb begin
    rd_data_s = ram_rdata_s;
    case (addr_q)
      ADDR_KBSR: rd_data_s = {kb_ready_q, 15'd0};
      ADDR_KBDR: rd_data_s = {8'd0, kb_data_q};
      ADDR_DSR:  rd_data_s = 16'h8000;
      ADDR_DDR:  rd_data_s = 16'h0000;
      default:   rd_data_s = ram_rdata_s;
    endcase
  end

  // Keyboard latch and display strobe; new keyboard data wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kb_ready_q   <= 1'b0;
      kb_data_q    <= 8'd0;
      disp_data_q  <= 8'd0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      if (kb_valid) begin
        kb_data_q  <= kb_data;
        kb_ready_q <= 1'b1;
      end else if (last_s && (state_q == ST_RD_WAIT) && (addr_q == ADDR_KBDR)) begin
        kb_ready_q <= 1'b0;
      end
      if (last_s && (state_q == ST_WR_WAIT) && (addr_q == ADDR_DDR)) begin
        disp_data_q  <= mdr_q[7:0];
        disp_valid_q <= 1'b1;
      end
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
`else
  logic unused_addr_s;

  assign addr_mmio_s = 1'b0;
  assign rd_data_s   = ram_rdata_s;
  // Upper address bits alias in RAM-only builds.
  assign unused_addr_s = ^{addr_q[15:DEPTH_LOG2], MARSpcIn[15:DEPTH_LOG2]};
`endif

  // Write port mux: preload only in IDLE, access commit only at completion.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = addr_q[DEPTH_LOG2-1:0];
    ram_wdata_s = mdr_q;
    if (state_q == ST_IDLE) begin
      if (ldMARSpcIn && !wr_req_s) begin
        ram_we_s    = 1'b1;
        ram_waddr_s = MARSpcIn[DEPTH_LOG2-1:0];
        ram_wdata_s = MDRSpcIn;
      end else begin
        ram_we_s = 1'b0;
      end
    end else if (last_s && (state_q == ST_WR_WAIT) && !addr_mmio_s) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  lc3_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (addr_q[DEPTH_LOG2-1:0]),
    .rdata (ram_rdata_s)
  );

  // Responder FSM with MAR/MDR and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 16'd0;
      mdr_q   <= 16'd0;
      addr_q  <= 16'd0;
      is_wr_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ldMAR) begin
            mar_q <= bus_in;
          end
          if (ldMDR && (selMDR == SEL_MDR_BUS)) begin
            mdr_q <= bus_in;
          end
          // Access uses the pre-edge MAR; write has priority over read.
          if (wr_req_s || rd_req_s) begin
            addr_q  <= mar_q;
            cnt_q   <= WAIT_INIT;
            busy_q  <= 1'b1;
            is_wr_q <= wr_req_s;
            state_q <= wr_req_s ? ST_WR_WAIT : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (state_q == ST_RD_WAIT) begin
              mdr_q <= rd_data_s;
            end
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!orig_req_s) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed self-checking bench for lc3_mem_responder (DEPTH_LOG2=10,
// WAIT_CYCLES=2). Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a period away from the active rising edge.
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_in = 16'd0;
  logic        ldMAR = 1'b0;
  logic        ldMDR = 1'b0;
  logic [1:0]  selMDR = 2'b00;
  logic        memWE = 1'b0;
  logic [15:0] MARSpcIn = 16'd0;
  logic [15:0] MDRSpcIn = 16'd0;
  logic        ldMARSpcIn = 1'b0;
  logic [15:0] mar_out;
  logic [15:0] mdr_out;
  logic        mem_ready;
  logic        busy;
`ifdef LC3_MMIO_EN
  logic [7:0]  kb_data = 8'd0;
  logic        kb_valid = 1'b0;
  logic [7:0]  disp_data;
  logic        disp_valid;
`endif

  int checks = 0;
  int fails  = 0;

  lc3_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .ldMAR      (ldMAR),
    .ldMDR      (ldMDR),
    .selMDR     (selMDR),
    .memWE      (memWE),
    .MARSpcIn   (MARSpcIn),
    .MDRSpcIn   (MDRSpcIn),
    .ldMARSpcIn (ldMARSpcIn),
`ifdef LC3_MMIO_EN
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
`endif
    .mar_out    (mar_out),
    .mdr_out    (mdr_out),
    .mem_ready  (mem_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive helpers (no checking inside).
  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); ldMARSpcIn = 1'b1; MARSpcIn = a; MDRSpcIn = d;
    @(negedge clk); ldMARSpcIn = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] d);
    @(negedge clk); ldMDR = 1'b1; selMDR = 2'b00; bus_in = d;
    @(negedge clk); ldMDR = 1'b0;
  endtask

  task automatic set_mar(input logic [15:0] a);
    @(negedge clk); ldMAR = 1'b1; bus_in = a;
    @(negedge clk); ldMAR = 1'b0;
  endtask

  // Called right after a request is raised on a falling edge.
  task automatic wait_ready(output int nbusy, output bit ok);
    nbusy = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ready) begin ok = 1'b1; break; end
      if (busy) nbusy++;
    end
  endtask

  task automatic drop_req();
    memWE = 1'b0; ldMDR = 1'b0; selMDR = 2'b00; ldMAR = 1'b0;
    @(negedge clk);
  endtask

  task automatic access(input bit wr, input logic [15:0] a,
                        output logic [15:0] data, output int nbusy, output bit ok);
    set_mar(a);
    if (wr) memWE = 1'b1;
    else begin ldMDR = 1'b1; selMDR = 2'b01; end
    wait_ready(nbusy, ok);
    data = mdr_out;
    drop_req();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mar_out, mdr_out, mem_ready, busy} !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: got mar=%h mdr=%h rdy=%b busy=%b, expected all 0",
               mar_out, mdr_out, mem_ready, busy);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_preload_read();
    logic [15:0] d; int nb; bit ok;
    preload(16'h0005, 16'h1234);
    access(1'b0, 16'h0005, d, nb, ok);
    checks++;
    if (ok !== 1'b1) begin fails++; $display("FAIL read_timeout: mem_ready=0 expected 1"); end
    checks++;
    if (nb !== 3) begin fails++; $display("FAIL read_busy_cycles: got %0d expected 3", nb); end
    checks++;
    if (d !== 16'h1234) begin fails++; $display("FAIL read_data: got %h expected 1234", d); end
    checks++;
    if (mem_ready !== 1'b0) begin fails++; $display("FAIL ready_fall: got %b expected 0", mem_ready); end
    checks++;
    if (mar_out !== 16'h0005) begin fails++; $display("FAIL mar_load: got %h expected 0005", mar_out); end
  endtask

  task automatic test_alias();
    logic [15:0] d; int nb; bit ok;
    set_mdr(16'hBEEF);
    checks++;
    if ({mdr_out, busy} !== {16'hBEEF, 1'b0}) begin
      fails++; $display("FAIL mdr_immediate: got mdr=%h busy=%b expected BEEF/0", mdr_out, busy);
    end
    access(1'b1, 16'h0400, d, nb, ok);
    checks++;
    if ({ok, nb} !== {1'b1, 32'd3}) begin
      fails++; $display("FAIL write_busy: got ok=%b busy=%0d expected 1/3", ok, nb);
    end
    set_mdr(16'h0000);
    access(1'b0, 16'h0000, d, nb, ok);
    checks++;
    if (d !== 16'hBEEF) begin fails++; $display("FAIL alias_read: got %h expected BEEF", d); end
  endtask

  task automatic test_hold_and_redirect();
    int nb; bit ok;
    // MAR=0 here; ldMAR on the accepting edge must not redirect the read.
    @(negedge clk); ldMDR = 1'b1; selMDR = 2'b01; ldMAR = 1'b1; bus_in = 16'h0005;
    @(negedge clk); ldMAR = 1'b0;
    checks++;
    if ({mar_out, busy} !== {16'h0005, 1'b1}) begin
      fails++; $display("FAIL mar_same_edge: got mar=%h busy=%b expected 0005/1", mar_out, busy);
    end
    wait_ready(nb, ok);
    checks++;
    if ({ok, mdr_out} !== {1'b1, 16'hBEEF}) begin
      fails++; $display("FAIL no_redirect: got ok=%b mdr=%h expected 1/BEEF", ok, mdr_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_ready, busy} !== 2'b10) begin
        fails++; $display("FAIL ready_hold%0d: got rdy=%b busy=%b expected 1/0", i, mem_ready, busy);
      end
    end
    ldMDR = 1'b0; selMDR = 2'b00;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin fails++; $display("FAIL ready_drop: got %b expected 0", mem_ready); end
    ldMDR = 1'b1; selMDR = 2'b01;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL next_accept: busy got %b expected 1", busy); end
    wait_ready(nb, ok);
    checks++;
    if ({ok, mdr_out} !== {1'b1, 16'h1234}) begin
      fails++; $display("FAIL second_read: got ok=%b mdr=%h expected 1/1234", ok, mdr_out);
    end
    drop_req();
  endtask

  task automatic test_write_priority_and_reset();
    logic [15:0] d; int nb; bit ok;
    preload(16'h0010, 16'h1111);
    set_mdr(16'h2222);
    set_mar(16'h0010);
    memWE = 1'b1; ldMDR = 1'b1; selMDR = 2'b01;
    wait_ready(nb, ok);
    checks++;
    if ({ok, mdr_out} !== {1'b1, 16'h2222}) begin
      fails++; $display("FAIL write_wins: got ok=%b mdr=%h expected 1/2222", ok, mdr_out);
    end
    drop_req();
    set_mdr(16'h0000);
    access(1'b0, 16'h0010, d, nb, ok);
    checks++;
    if (d !== 16'h2222) begin fails++; $display("FAIL write_commit: got %h expected 2222", d); end
    // Abort a write part-way through WR_WAIT.
    set_mdr(16'h3333);
    memWE = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wr_wait_entry: busy got %b expected 1", busy); end
    @(negedge clk);
    reset = 1'b0; memWE = 1'b0;
    #1;
    checks++;
    if ({mar_out, mdr_out, mem_ready, busy} !== 34'd0) begin
      fails++; $display("FAIL reset_abort: got mar=%h mdr=%h rdy=%b busy=%b expected all 0",
                        mar_out, mdr_out, mem_ready, busy);
    end
    @(negedge clk); reset = 1'b1;
    access(1'b0, 16'h0010, d, nb, ok);
    checks++;
    if (d !== 16'h2222) begin fails++; $display("FAIL abort_no_write: got %h expected 2222", d); end
  endtask

`ifdef LC3_MMIO_EN
  task automatic test_mmio();
    logic [15:0] d; int nb; bit ok;
    @(negedge clk); kb_data = 8'h41; kb_valid = 1'b1;
    @(negedge clk); kb_valid = 1'b0;
    access(1'b0, 16'hFE00, d, nb, ok);
    checks++;
    if (d !== 16'h8000) begin fails++; $display("FAIL kbsr_set: got %h expected 8000", d); end
    access(1'b0, 16'hFE02, d, nb, ok);
    checks++;
    if (d !== 16'h0041) begin fails++; $display("FAIL kbdr: got %h expected 0041", d); end
    access(1'b0, 16'hFE00, d, nb, ok);
    checks++;
    if (d !== 16'h0000) begin fails++; $display("FAIL kbsr_clear: got %h expected 0000", d); end
    set_mdr(16'h0058);
    set_mar(16'hFE06);
    memWE = 1'b1;
    wait_ready(nb, ok);
    checks++;
    if ({disp_valid, disp_data} !== {1'b1, 8'h58}) begin
      fails++; $display("FAIL ddr_write: got valid=%b data=%h expected 1/58", disp_valid, disp_data);
    end
    drop_req();
    checks++;
    if (disp_valid !== 1'b0) begin fails++; $display("FAIL ddr_pulse: valid got %b expected 0", disp_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_preload_read();
    test_alias();
    test_hold_and_redirect();
    test_write_priority_and_reset();
`ifdef LC3_MMIO_EN
    test_mmio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
